// File: rtl/eigen_pkg.sv
// Shared types and width helpers for the Rayleigh-quotient engine.
package eigen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROW_MAC,
    ROW_ACC,
    DONE
  } state_e;

  function automatic int t_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic int num_width(input int n, input int dw);
    return t_width(n, dw) + dw + $clog2(n);
  endfunction

  function automatic int den_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  // LSB of element (row,col) in a row-major packed bus; a vector is row 0.
  function automatic int elem_lsb(input int row, input int col, input int n, input int dw);
    return (row * n + col) * dw;
  endfunction

endpackage

// File: rtl/signed_mac.sv
// Signed multiply-accumulate with synchronous clear and enable.
// NEXT_OUT selects whether acc shows the registered or the about-to-be-registered sum.
module signed_mac #(
  parameter int A_W      = 32,
  parameter int B_W      = 32,
  parameter int ACC_W    = 67,
  parameter bit NEXT_OUT = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  always_comb begin
    prod     = a * b;
    prod_ext = {{(ACC_W - P_W){prod[P_W-1]}}, prod};
    acc_d    = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = NEXT_OUT ? acc_d : acc_q;

endmodule

// File: rtl/eigen_rayleigh_seq.sv
// Sequential Rayleigh-quotient engine: computes v^T*A*v and v^T*v
// row by row, presenting both through valid/ready handshakes.
module eigen_rayleigh_seq
  import eigen_pkg::*;
#(
  parameter  int SIZE_N = 8,
  parameter  int DATA_W = 32,
  localparam int T_W    = t_width(SIZE_N, DATA_W),
  localparam int NUM_W  = num_width(SIZE_N, DATA_W),
  localparam int DEN_W  = den_width(SIZE_N, DATA_W)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SIZE_N*SIZE_N*DATA_W-1:0]   mat_in,
  input  logic [SIZE_N*DATA_W-1:0]          vec_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [NUM_W-1:0]           num_out,
  output logic signed [DEN_W-1:0]           den_out,
  output logic                              busy
);

  localparam int IDX_W = $clog2(SIZE_N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE_N - 1);

  state_e state_q, state_d;

  logic [SIZE_N*SIZE_N*DATA_W-1:0] mat_q, mat_d;
  logic [SIZE_N*DATA_W-1:0]        vec_q, vec_d;
  logic [IDX_W-1:0]                i_q, i_d;
  logic [IDX_W-1:0]                j_q, j_d;
  logic signed [NUM_W-1:0]         num_out_q, num_out_d;
  logic signed [DEN_W-1:0]         den_out_q, den_out_d;

  logic                    accept;
  logic                    last_row;
  logic                    last_col;
  logic signed [DATA_W-1:0] a_ij;
  logic signed [DATA_W-1:0] v_j;
  logic signed [DATA_W-1:0] v_i;
  logic signed [T_W-1:0]    row_sum;
  logic signed [NUM_W-1:0]  num_next;
  logic signed [DEN_W-1:0]  den_next;

  assign accept   = in_valid && (state_q == IDLE);
  assign last_row = (i_q == LAST_IDX);
  assign last_col = (j_q == LAST_IDX);
  assign a_ij     = mat_q[elem_lsb(int'(i_q), int'(j_q), SIZE_N, DATA_W) +: DATA_W];
  assign v_j      = vec_q[elem_lsb(0, int'(j_q), SIZE_N, DATA_W) +: DATA_W];
  assign v_i      = vec_q[elem_lsb(0, int'(i_q), SIZE_N, DATA_W) +: DATA_W];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ROW_MAC;
      ROW_MAC: if (last_col) state_d = ROW_ACC;
      ROW_ACC: state_d = last_row ? DONE : ROW_MAC;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == ROW_MAC) || (state_q == ROW_ACC);
  end

  // Row partial sum t: cleared on acceptance and after it is folded into num.
  signed_mac #(
    .A_W(DATA_W), .B_W(DATA_W), .ACC_W(T_W), .NEXT_OUT(1'b0)
  ) u_row_mac (
    .clk (clk),
    .rst (rst),
    .clr (accept || (state_q == ROW_ACC)),
    .en  (state_q == ROW_MAC),
    .a   (a_ij),
    .b   (v_j),
    .acc (row_sum)
  );

  signed_mac #(
    .A_W(T_W), .B_W(DATA_W), .ACC_W(NUM_W), .NEXT_OUT(1'b1)
  ) u_num_mac (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (state_q == ROW_ACC),
    .a   (row_sum),
    .b   (v_i),
    .acc (num_next)
  );

  signed_mac #(
    .A_W(DATA_W), .B_W(DATA_W), .ACC_W(DEN_W), .NEXT_OUT(1'b1)
  ) u_den_mac (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (state_q == ROW_ACC),
    .a   (v_i),
    .b   (v_i),
    .acc (den_next)
  );

  // Results are published only on the final ROW_ACC so they stay stable afterwards.
  always_comb begin
    mat_d     = mat_q;
    vec_d     = vec_q;
    i_d       = i_q;
    j_d       = j_q;
    num_out_d = num_out_q;
    den_out_d = den_out_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mat_d = mat_in;
          vec_d = vec_in;
          i_d   = '0;
          j_d   = '0;
        end
      end
      ROW_MAC: begin
        j_d = last_col ? '0 : j_q + 1'b1;
      end
      ROW_ACC: begin
        j_d = '0;
        if (last_row) begin
          i_d       = '0;
          num_out_d = num_next;
          den_out_d = den_next;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      default: begin
        i_d = '0;
        j_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mat_q     <= '0;
      vec_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      num_out_q <= '0;
      den_out_q <= '0;
    end else begin
      mat_q     <= mat_d;
      vec_q     <= vec_d;
      i_q       <= i_d;
      j_q       <= j_d;
      num_out_q <= num_out_d;
      den_out_q <= den_out_d;
    end
  end

  assign num_out = num_out_q;
  assign den_out = den_out_q;

endmodule

// File: tb/tb_eigen_rayleigh_seq.sv
// Directed bench for eigen_rayleigh_seq: a 4x4/8-bit instance for the
// functional table and corner sequences, an 8x8/32-bit instance for extremes.
module tb_eigen_rayleigh_seq;

  logic clk;
  logic rst;

  // 4x4, 8-bit instance: T_W=18, NUM_W=28, DEN_W=18
  logic                in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [127:0]        mat_in4;
  logic [31:0]         vec_in4;
  logic signed [27:0]  num_out4;
  logic signed [17:0]  den_out4;

  // 8x8, 32-bit instance: NUM_W=102, DEN_W=67
  logic                in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [2047:0]       mat_in8;
  logic [255:0]        vec_in8;
  logic signed [101:0] num_out8;
  logic signed [66:0]  den_out8;

  int checks;
  int errors;

  eigen_rayleigh_seq #(.SIZE_N(4), .DATA_W(8)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .mat_in    (mat_in4),
    .vec_in    (vec_in4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .num_out   (num_out4),
    .den_out   (den_out4),
    .busy      (busy4)
  );

  eigen_rayleigh_seq #(.SIZE_N(8), .DATA_W(32)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .mat_in    (mat_in8),
    .vec_in    (vec_in8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .num_out   (num_out8),
    .den_out   (den_out8),
    .busy      (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string              name;
    logic [127:0]       mat;
    logic [31:0]        vec;
    logic signed [27:0] num;
    logic signed [17:0] den;
  } vec_t;

  vec_t tbl[5];

  // Diagonal elements get d, off-diagonal elements get off.
  function automatic logic [127:0] mat_fill(input int d, input int off);
    logic [127:0] m;
    m = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        m[(r*4+c)*8 +: 8] = (r == c) ? 8'(d) : 8'(off);
      end
    end
    return m;
  endfunction

  function automatic logic [31:0] vec4(input int e0, input int e1, input int e2, input int e3);
    return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  task automatic check_output(input string name, input logic signed [127:0] act,
                              input logic signed [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [127:0] m, input logic [31:0] v);
    @(negedge clk);
    check_output("accept_in_ready", in_ready4, 1);
    in_valid4 = 1'b1;
    mat_in4   = m;
    vec_in4   = v;
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
  endtask

  task automatic wait_result(input int start, output int cycles);
    cycles = start;
    while (out_valid4 !== 1'b1 && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic handshake(input logic signed [27:0] num, input logic signed [17:0] den);
    @(negedge clk);
    out_ready4 = 1'b1;
    @(posedge clk);
    #1;
    out_ready4 = 1'b0;
    check_output("hs_out_valid_drop", out_valid4, 0);
    check_output("hs_in_ready", in_ready4, 1);
    check_output("hs_num_retained", num_out4, num);
    check_output("hs_den_retained", den_out4, den);
  endtask

  initial begin
    int cycles;
    logic signed [127:0] exp_num8;
    logic signed [127:0] exp_den8;

    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    in_valid4  = 1'b0;
    out_ready4 = 1'b0;
    mat_in4    = '0;
    vec_in4    = '0;
    in_valid8  = 1'b0;
    out_ready8 = 1'b0;
    mat_in8    = '0;
    vec_in8    = '0;

    tbl[0] = '{"identity",  mat_fill(1, 0),      vec4(1, 2, 3, 4),         28'sd30,       18'sd30};
    tbl[1] = '{"two_i",     mat_fill(2, 0),      vec4(1, 1, 1, 1),         28'sd8,        18'sd4};
    tbl[2] = '{"neg_ones",  mat_fill(-1, -1),    vec4(1, -1, 1, -1),       28'sd0,        18'sd4};
    tbl[3] = '{"threes",    mat_fill(3, 3),      vec4(-2, -2, -2, -2),     28'sd192,      18'sd16};
    tbl[4] = '{"max8",      mat_fill(127, 127),  vec4(-128, -128, -128, -128), 28'sd33292288, 18'sd65536};

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_in_ready4", in_ready4, 1);
    check_output("rst_out_valid4", out_valid4, 0);
    check_output("rst_busy4", busy4, 0);
    check_output("rst_num4", num_out4, 0);
    check_output("rst_den4", den_out4, 0);
    check_output("rst_in_ready8", in_ready8, 1);
    check_output("rst_out_valid8", out_valid8, 0);
    check_output("rst_busy8", busy8, 0);
    check_output("rst_num8", num_out8, 0);
    check_output("rst_den8", den_out8, 0);
    @(negedge clk);
    rst = 1'b1;

    // Entries run back to back: each new start follows the previous handshake.
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(tbl[k].mat, tbl[k].vec);
      check_output({tbl[k].name, "_busy"}, busy4, 1);
      wait_result(0, cycles);
      check_output({tbl[k].name, "_latency"}, cycles, 20);
      check_output({tbl[k].name, "_num"}, num_out4, tbl[k].num);
      check_output({tbl[k].name, "_den"}, den_out4, tbl[k].den);
      handshake(tbl[k].num, tbl[k].den);
    end

    // Back-pressure: results hold and new operands are ignored while DONE.
    apply_stimulus(mat_fill(2, 0), vec4(1, 1, 1, 1));
    wait_result(0, cycles);
    check_output("hold_latency", cycles, 20);
    @(negedge clk);
    in_valid4 = 1'b1;
    mat_in4   = mat_fill(3, 3);
    vec_in4   = vec4(5, 5, 5, 5);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check_output("hold_num", num_out4, 8);
      check_output("hold_den", den_out4, 4);
      check_output("hold_in_ready", in_ready4, 0);
      check_output("hold_out_valid", out_valid4, 1);
    end
    in_valid4 = 1'b0;
    handshake(28'sd8, 18'sd4);
    @(posedge clk);
    #1;
    check_output("hold_idle_busy", busy4, 0);

    // Operand changes after acceptance must not affect the result.
    apply_stimulus(mat_fill(1, 0), vec4(1, 2, 3, 4));
    repeat (3) @(posedge clk);
    #1;
    mat_in4 = mat_fill(3, 3);
    vec_in4 = vec4(-2, -2, -2, -2);
    wait_result(3, cycles);
    check_output("change_latency", cycles, 20);
    check_output("change_num", num_out4, 30);
    check_output("change_den", den_out4, 30);
    handshake(28'sd30, 18'sd30);

    // Abort mid-ROW_MAC, then a clean run must show no residue.
    apply_stimulus(mat_fill(3, 3), vec4(-2, -2, -2, -2));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_output("abort_busy", busy4, 0);
    check_output("abort_in_ready", in_ready4, 1);
    check_output("abort_out_valid", out_valid4, 0);
    check_output("abort_num", num_out4, 0);
    check_output("abort_den", den_out4, 0);
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(mat_fill(2, 0), vec4(1, 1, 1, 1));
    wait_result(0, cycles);
    check_output("post_abort_latency", cycles, 20);
    check_output("post_abort_num", num_out4, 8);
    check_output("post_abort_den", den_out4, 4);
    handshake(28'sd8, 18'sd4);

    // Extremes on the 8x8/32-bit instance: num = 64*(-2^31)^3, den = 8*2^62.
    exp_num8 = -(128'sd1 <<< 99);
    exp_den8 = 128'sd1 <<< 65;
    @(negedge clk);
    check_output("ext_in_ready", in_ready8, 1);
    in_valid8 = 1'b1;
    mat_in8   = {64{32'h8000_0000}};
    vec_in8   = {8{32'h8000_0000}};
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    cycles = 0;
    while (out_valid8 !== 1'b1 && cycles < 300) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check_output("ext_latency", cycles, 72);
    check_output("ext_num", num_out8, exp_num8);
    check_output("ext_den", den_out8, exp_den8);
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    out_ready8 = 1'b0;
    check_output("ext_hs_out_valid", out_valid8, 0);
    check_output("ext_hs_in_ready", in_ready8, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
